// File: rtl/gouram_tracker_pkg.sv
// Shared types and helpers for the signal tracker history buffer.
// Holds the request state encoding and the circular address computation.
package gouram_tracker_pkg;

  localparam int unsigned DEFAULT_BUFFER_DEPTH = 64;
  localparam int unsigned PTR_WIDTH = $clog2(DEFAULT_BUFFER_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDone
  } state_e;

  // Slot holding the entry recorded k cycles before the cycle whose write pointer is wr_ptr.
  function automatic logic [31:0] wrap_addr(input logic [31:0] wr_ptr, input logic [31:0] k,
                                            input int unsigned depth);
    return (wr_ptr - k) & (depth - 1);
  endfunction

endpackage

// File: rtl/signal_history_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on contents.
module signal_history_ram #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/signal_history_buffer.sv
// Circular per-cycle history of tracked_signal with a two-cycle lookback query port.
// Requests are range-checked at acceptance; out-of-range lookbacks return zero with an error.
module signal_history_buffer
  import gouram_tracker_pkg::*;
#(
  parameter int unsigned TRACKED_SIGNAL_WIDTH = 1,
  parameter int unsigned BUFFER_DEPTH         = DEFAULT_BUFFER_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [TRACKED_SIGNAL_WIDTH-1:0] tracked_signal,
  input  logic [31:0]                     cycles_back_to_recall,
  input  logic                            recalculate_back_cycle,
  output logic [TRACKED_SIGNAL_WIDTH-1:0] signal_recall,
  output logic                            data_valid,
  output logic                            recall_error,
  output logic                            busy
);

  localparam int unsigned PtrW  = $clog2(BUFFER_DEPTH);
  localparam int unsigned FillW = PtrW + 1;
  localparam logic [FillW-1:0] FillMax = FillW'(BUFFER_DEPTH);
  localparam logic [FillW-1:0] KMax    = FillW'(BUFFER_DEPTH - 2);

  state_e state_q, state_d;

  logic [PtrW-1:0]                 wr_ptr_q;
  logic [FillW-1:0]                fill_q;
  logic [FillW-1:0]                k_limit;
  logic [PtrW-1:0]                 req_addr;
  logic [PtrW-1:0]                 rd_addr_q;
  logic                            err_q;
  logic                            req_ok;
  logic                            accept;
  logic                            rd_en;
  logic [TRACKED_SIGNAL_WIDTH-1:0] rd_data;
  logic [TRACKED_SIGNAL_WIDTH-1:0] recall_q;
  logic                            recall_err_q;
  logic signed [32:0]              k_ext;
  logic signed [32:0]              limit_ext;

  // Recording runs every cycle regardless of request state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (fill_q != FillMax) begin
        fill_q <= fill_q + FillW'(1);
      end
    end
  end

  // Sign-extend to 33 bits so negative lookbacks fail the lower bound instead of wrapping.
  always_comb begin
    k_limit   = (fill_q > KMax) ? KMax : fill_q;
    k_ext     = signed'({cycles_back_to_recall[31], cycles_back_to_recall});
    limit_ext = signed'(33'(k_limit));
    req_ok    = !k_ext[32] && (k_ext <= limit_ext);
  end

  assign req_addr = PtrW'(wrap_addr(32'(wr_ptr_q), cycles_back_to_recall, BUFFER_DEPTH));
  assign accept   = recalculate_back_cycle && (state_q != StRead);
  assign rd_en    = (state_q == StRead) && !err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      rd_addr_q <= req_addr;
      err_q     <= !req_ok;
    end
  end

  signal_history_ram #(
    .WIDTH(TRACKED_SIGNAL_WIDTH),
    .DEPTH(BUFFER_DEPTH),
    .AW   (PtrW)
  ) u_ram (
    .clk  (clk),
    .we   (rst_n),
    .waddr(wr_ptr_q),
    .wdata(tracked_signal),
    .re   (rd_en),
    .raddr(rd_addr_q),
    .rdata(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = recalculate_back_cycle ? StRead : StIdle;
      StRead:  state_d = StDone;
      StDone:  state_d = recalculate_back_cycle ? StRead : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Results are visible combinationally in DONE and held in registers afterwards.
  always_comb begin
    data_valid    = (state_q == StDone);
    busy          = (state_q == StRead);
    signal_recall = recall_q;
    recall_error  = recall_err_q;
    if (state_q == StDone) begin
      signal_recall = err_q ? '0 : rd_data;
      recall_error  = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recall_q     <= '0;
      recall_err_q <= 1'b0;
    end else if (state_q == StDone) begin
      recall_q     <= signal_recall;
      recall_err_q <= recall_error;
    end
  end

endmodule

// File: tb/tb_signal_history_buffer.sv
// Self-checking bench for signal_history_buffer: directed and random lookback requests
// compared against a cycle-indexed history model.
module tb_signal_history_buffer;

  localparam int W     = 8;
  localparam int DEPTH = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] tracked_signal;
  logic [31:0]  cycles_back_to_recall;
  logic         recalculate_back_cycle;
  logic [W-1:0] signal_recall;
  logic         data_valid;
  logic         recall_error;
  logic         busy;

  signal_history_buffer #(
    .TRACKED_SIGNAL_WIDTH(W),
    .BUFFER_DEPTH        (DEPTH)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .tracked_signal        (tracked_signal),
    .cycles_back_to_recall (cycles_back_to_recall),
    .recalculate_back_cycle(recalculate_back_cycle),
    .signal_recall         (signal_recall),
    .data_valid            (data_valid),
    .recall_error          (recall_error),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: hist[c] is the value driven in cycle c since the last reset release.
  int   hist[$];
  int   cyc;
  logic acc1, acc2, err1, err2;
  int   val1, val2, last_val;
  logic last_err;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    cyc      = 0;
    acc1     = 1'b0;
    acc2     = 1'b0;
    err1     = 1'b0;
    err2     = 1'b0;
    val1     = 0;
    val2     = 0;
    last_val = 0;
    last_err = 1'b0;
  endtask

  // Drives one cycle, advances the model to the next cycle and checks all outputs there.
  task automatic step(input logic s, input int k, input logic [W-1:0] v);
    logic acc;
    logic ok;
    int   fill;
    int   nval;
    logic nerr;
    tracked_signal         = v;
    recalculate_back_cycle = s;
    cycles_back_to_recall  = k;
    hist.push_back(int'(v));
    acc  = s && !acc1;
    nval = 0;
    nerr = 1'b0;
    if (acc) begin
      fill = (cyc < DEPTH) ? cyc : DEPTH;
      ok   = (k >= 0) && (k <= fill) && (k <= DEPTH - 2);
      nerr = !ok;
      nval = ok ? hist[cyc - k] : 0;
    end
    @(posedge clk);
    cyc++;
    acc2 = acc1;
    err2 = err1;
    val2 = val1;
    acc1 = acc;
    err1 = nerr;
    val1 = nval;
    if (acc2) begin
      last_val = val2;
      last_err = err2;
    end
    #1;
    check("busy", int'(busy), int'(acc1));
    check("data_valid", int'(data_valid), int'(acc2));
    check("recall_error", int'(recall_error), int'(last_err));
    check("signal_recall", int'(signal_recall), last_val);
    recalculate_back_cycle = 1'b0;
  endtask

  initial begin
    logic s;
    int   k;
    rst_n                  = 1'b0;
    tracked_signal         = '0;
    cycles_back_to_recall  = '0;
    recalculate_back_cycle = 1'b0;
    model_reset();
    #1;
    check("rst_data_valid", int'(data_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_recall_error", int'(recall_error), 0);
    check("rst_signal_recall", int'(signal_recall), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed phase: tracked_signal equals the cycle index.
    for (int c = 0; c < 210; c++) begin
      s = 1'b1;
      case (c)
        3:       k = 5;
        10:      k = 0;
        20:      k = 3;
        30:      k = -1;
        50:      k = 4;
        51:      k = 2;
        52:      k = 1;
        200:     k = 62;
        202:     k = 63;
        204:     k = 32'h8000_0000;
        206:     k = 64;
        default: begin
          s = 1'b0;
          k = 0;
        end
      endcase
      step(s, k, W'(c));
      if (cyc == 5)   check("tp_k5_fill3_err", int'(recall_error), 1);
      if (cyc == 5)   check("tp_k5_fill3_val", int'(signal_recall), 0);
      if (cyc == 12)  check("tp_k0_val", int'(signal_recall), 10);
      if (cyc == 22)  check("tp_k3_val", int'(signal_recall), 17);
      if (cyc == 32)  check("tp_kneg_err", int'(recall_error), 1);
      if (cyc == 51)  check("tp_busy51", int'(busy), 1);
      if (cyc == 53)  check("tp_no_result53", int'(data_valid), 0);
      if (cyc == 54)  check("tp_k1_at52", int'(signal_recall), 51);
      if (cyc == 202) check("tp_k62_wrap", int'(signal_recall), 138);
      if (cyc == 204) check("tp_k63_err", int'(recall_error), 1);
    end

    // Random phase.
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 9) < 4);
      k = int'($urandom_range(0, 72)) - 4;
      step(s, k, W'($urandom));
    end

    // Reset while a request is in READ.
    step(1'b0, 0, W'($urandom));
    step(1'b1, 2, W'($urandom));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_data_valid", int'(data_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_recall_error", int'(recall_error), 0);
    check("midrst_signal_recall", int'(signal_recall), 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    step(1'b1, 0, 8'hA5);
    step(1'b1, 1, 8'h11);
    step(1'b1, 2, 8'h22);
    step(1'b0, 0, 8'h33);
    step(1'b1, 5, 8'h44);
    step(1'b1, 1, 8'h55);
    step(1'b1, 4, 8'h66);
    step(1'b0, 0, 8'h77);
    check("post_rst_k4", int'(signal_recall), 8'h22);
    for (int i = 0; i < 120; i++) begin
      s = ($urandom_range(0, 9) < 5);
      k = int'($urandom_range(0, 12)) - 1;
      step(s, k, W'($urandom));
    end
    step(1'b0, 0, 8'h00);
    step(1'b0, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
